// File: rtl/paddle_ctrl.sv
// paddle_ctrl
//   Controls one Pong paddle's vertical position. The paddle moves on prescaled
//   ticks and accelerates while a direction is held. It runs either from two
//   active-low buttons or in auto mode, where it tracks the ball row. The block
//   also outputs the paddle's bounding box, the pixel-hit flag and the colour.
//
// Ports
//   CLK, RST_N            system clock, asynchronous active-low reset
//   prescaler             tick period minus 1
//   x, y                  current scan pixel
//   x_pos                 paddle left column
//   up_button/down_button active-low buttons, asynchronous to CLK
//   auto_mode             1 = track ball_y and ignore the buttons
//   ball_y                ball centre row
//   paddle_on             (x,y) lies inside the paddle box (combinational)
//   bar_rgb               paddle colour
//   BAR_X_L/R, BAR_Y_T/B  paddle bounding box
//   speed                 current step magnitude, 0 when idle
//
// FSM
//   state  | meaning
//   IDLE   | no request on the last tick, speed 0
//   UP     | moving toward row 0, speed ramps to V_MAX
//   DOWN   | moving toward MAX_Y-PADDLE_H, speed ramps to V_MAX
module paddle_ctrl #(
  parameter int          MAX_Y    = 480,
  parameter int          PADDLE_W = 3,
  parameter int          PADDLE_H = 72,
  parameter int          V_MAX    = 8,
  parameter int          DEADBAND = 4,
  parameter int          PS_W     = 22,
  parameter logic [7:0]  RGB      = 8'b000_11100
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [PS_W-1:0] prescaler,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic [9:0]      x_pos,
  input  logic            up_button,
  input  logic            down_button,
  input  logic            auto_mode,
  input  logic [9:0]      ball_y,
  output logic            paddle_on,
  output logic [7:0]      bar_rgb,
  output logic [9:0]      BAR_X_L,
  output logic [9:0]      BAR_X_R,
  output logic [9:0]      BAR_Y_T,
  output logic [9:0]      BAR_Y_B,
  output logic [3:0]      speed
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  localparam logic [9:0] Y_LIMIT = 10'(MAX_Y - PADDLE_H);
  localparam logic [9:0] Y_RESET = 10'((MAX_Y - PADDLE_H) / 2);

  logic            r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
  logic [PS_W-1:0] r_cnt;
  logic [1:0]      r_state;
  logic [3:0]      r_speed;
  logic [9:0]      r_y;

  logic            w_tick;
  logic [1:0]      w_req;
  logic [10:0]     w_ctr;
  logic [1:0]      w_state_nxt;
  logic [3:0]      w_speed_nxt;
  logic [9:0]      w_y_nxt;
  logic [9:0]      w_step;
  logic [10:0]     w_sum;

  // The buttons idle high, so the synchroniser also resets high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_up_s1 <= 1'b1;
      r_up_s2 <= 1'b1;
      r_dn_s1 <= 1'b1;
      r_dn_s2 <= 1'b1;
    end else begin
      r_up_s1 <= up_button;
      r_up_s2 <= r_up_s1;
      r_dn_s1 <= down_button;
      r_dn_s2 <= r_dn_s1;
    end
  end

  // Free-running counter that matches on equality only. If prescaler is
  // lowered below the current count, the counter wraps around and then matches.
  assign w_tick = (r_cnt == prescaler);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  // In auto mode the request is computed in 11 bits so that the centre
  // plus the deadband cannot overflow.
  assign w_ctr = {1'b0, r_y} + 11'(PADDLE_H / 2);

  always_comb begin
    w_req = S_IDLE;
    if (auto_mode) begin
      if (({1'b0, ball_y} + 11'(DEADBAND)) < w_ctr) w_req = S_UP;
      else if ({1'b0, ball_y} > (w_ctr + 11'(DEADBAND))) w_req = S_DOWN;
    end else begin
      if (!r_up_s2 && r_dn_s2) w_req = S_UP;
      else if (!r_dn_s2 && r_up_s2) w_req = S_DOWN;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
    w_y_nxt     = r_y;
    w_step      = '0;
    w_sum       = '0;
    if (w_tick) begin
      if (w_req == S_IDLE) begin
        w_state_nxt = S_IDLE;
        w_speed_nxt = '0;
      end else if (w_req == r_state) begin
        w_speed_nxt = (r_speed >= 4'(V_MAX)) ? 4'(V_MAX) : r_speed + 4'd1;
      end else begin
        w_state_nxt = w_req;
        w_speed_nxt = 4'd1;
      end
      // The paddle moves by the speed that was just computed. Both bounds are
      // checked before the move is applied, so the position saturates instead
      // of wrapping.
      w_step = {6'b0, w_speed_nxt};
      w_sum  = {1'b0, r_y} + {1'b0, w_step};
      if (w_req == S_UP)
        w_y_nxt = (r_y >= w_step) ? r_y - w_step : 10'd0;
      else if (w_req == S_DOWN)
        w_y_nxt = (w_sum <= {1'b0, Y_LIMIT}) ? w_sum[9:0] : Y_LIMIT;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_speed <= '0;
      r_y     <= Y_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_speed <= w_speed_nxt;
      r_y     <= w_y_nxt;
    end
  end

  assign bar_rgb   = RGB;
  assign speed     = r_speed;
  assign BAR_X_L   = x_pos;
  assign BAR_X_R   = x_pos + 10'(PADDLE_W);
  assign BAR_Y_T   = r_y;
  assign BAR_Y_B   = r_y + 10'(PADDLE_H - 1);
  assign paddle_on = (x >= BAR_X_L) && (x <= BAR_X_R) &&
                     (y >= BAR_Y_T) && (y <= BAR_Y_B);

endmodule
